// File: rtl/cmsdk_mcu_rstctrl.sv
//==============================================================================
// Module   : cmsdk_mcu_rstctrl
// Purpose  : MCU reset controller. Holds the debug, AHB and APB domains in
//            reset, then releases them in order DBGRESETn -> HRESETn ->
//            PRESETn. Records sticky reset causes.
// Option   : `define CMSDK_RSTCTRL_SYNC_EN to pass the request inputs through
//            a 2-flop FCLK synchroniser (adds 2 cycles of request latency).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cmsdk_mcu_rstctrl #(
  parameter int NUM_REQ    = 4,
  parameter int RST_CYCLES = 16,
  parameter int STAGGER    = 2
) (
  input  logic               FCLK,
  input  logic               PORESET,
  input  logic [NUM_REQ-1:0] SYSRESETREQ,
  input  logic [NUM_REQ-1:0] REQ_MASK,
  input  logic               LOCKUP,
  input  logic               LOCKUPRESET,
  input  logic               DBGRESETREQ,
  input  logic               RSTCAUSE_CLR,
  output logic               DBGRESETn,
  output logic               HRESETn,
  output logic               PRESETn,
  output logic [NUM_REQ+2:0] RSTCAUSE,
  output logic               BUSY
);

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_REL_H = 2'd1;
  localparam logic [1:0] ST_REL_P = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  localparam logic [7:0] HOLD_LAST = 8'(RST_CYCLES - 1);
  localparam logic [7:0] STAG_LAST = 8'(STAGGER - 1);

  // Request inputs as seen by the controller
  logic [NUM_REQ-1:0] sysreq_in;
  logic               lockup_in;
  logic               lockuprst_in;
  logic               dbgreq_in;

`ifdef CMSDK_RSTCTRL_SYNC_EN
  logic [NUM_REQ+2:0] sync1_q;
  logic [NUM_REQ+2:0] sync2_q;

  // Two-stage synchroniser for the asynchronous request sources
  always_ff @(posedge FCLK or posedge PORESET) begin
    if (PORESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {DBGRESETREQ, LOCKUPRESET, LOCKUP, SYSRESETREQ};
      sync2_q <= sync1_q;
    end
  end

  assign {dbgreq_in, lockuprst_in, lockup_in, sysreq_in} = sync2_q;
`else
  assign sysreq_in    = SYSRESETREQ;
  assign lockup_in    = LOCKUP;
  assign lockuprst_in = LOCKUPRESET;
  assign dbgreq_in    = DBGRESETREQ;
`endif

  // Qualified request terms; masking is applied after synchronisation
  logic [NUM_REQ-1:0] sys_bits;
  logic               lockup_req;
  logic               sys_req;
  logic               any_req;

  assign sys_bits   = sysreq_in & ~REQ_MASK;
  assign lockup_req = lockup_in & lockuprst_in;
  assign sys_req    = (|sys_bits) | lockup_req;
  assign any_req    = sys_req | dbgreq_in;

  logic [1:0]         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               dbg_q, dbg_d;
  logic               h_q, h_d;
  logic               p_q, p_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ+2:0] cause_q, cause_d;

  // State register; PORESET forces the full reset picture asynchronously
  always_ff @(posedge FCLK or posedge PORESET) begin
    if (PORESET) begin
      state_q <= ST_HOLD;
      cnt_q   <= 8'd0;
      dbg_q   <= 1'b0;
      h_q     <= 1'b0;
      p_q     <= 1'b0;
      busy_q  <= 1'b1;
      cause_q <= (NUM_REQ+3)'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dbg_q   <= dbg_d;
      h_q     <= h_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
    end
  end

  // Next-state: hold window checked only at its last count, staggered releases
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (cnt_q >= HOLD_LAST) begin
          cnt_d = 8'd0;
          if (!any_req) state_d = ST_REL_H;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_REL_H: begin
        if (any_req) begin
          state_d = ST_HOLD;
          cnt_d   = 8'd0;
        end else if (cnt_q >= STAG_LAST) begin
          state_d = ST_REL_P;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_REL_P: begin
        if (any_req) begin
          state_d = ST_HOLD;
          cnt_d   = 8'd0;
        end else if (cnt_q >= STAG_LAST) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        if (any_req) begin
          state_d = ST_HOLD;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Output next values: releases on exit edges, requests re-assert domains
  always_comb begin
    dbg_d = dbg_q;
    h_d   = h_q;
    p_d   = p_q;
    case (state_q)
      ST_HOLD:  if (cnt_q >= HOLD_LAST && !any_req) dbg_d = 1'b1;
      ST_REL_H: if (cnt_q >= STAG_LAST && !any_req) h_d = 1'b1;
      ST_REL_P: if (cnt_q >= STAG_LAST && !any_req) p_d = 1'b1;
      default:  ;
    endcase
    if (any_req) begin
      h_d = 1'b0;
      p_d = 1'b0;
    end
    // A debug request always pulls the debug domain back into reset
    if (dbgreq_in) dbg_d = 1'b0;
    busy_d  = (state_d != ST_RUN);
    // New causes OR in after the clear so a same-cycle cause survives
    cause_d = (RSTCAUSE_CLR ? '0 : cause_q) | {sys_bits, dbgreq_in, lockup_req, 1'b0};
  end

  assign DBGRESETn = dbg_q;
  assign HRESETn   = h_q;
  assign PRESETn   = p_q;
  assign BUSY      = busy_q;
  assign RSTCAUSE  = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_cmsdk_mcu_rstctrl.sv
//==============================================================================
// Module   : tb_cmsdk_mcu_rstctrl
// Purpose  : Self-checking bench for cmsdk_mcu_rstctrl (default build).
//            Reference model tracks the age of the current reset sequence.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cmsdk_mcu_rstctrl;

  localparam int NR = 4;
  localparam int RC = 16;
  localparam int ST = 2;

  logic          FCLK;
  logic          PORESET;
  logic [NR-1:0] SYSRESETREQ;
  logic [NR-1:0] REQ_MASK;
  logic          LOCKUP;
  logic          LOCKUPRESET;
  logic          DBGRESETREQ;
  logic          RSTCAUSE_CLR;
  logic          DBGRESETn;
  logic          HRESETn;
  logic          PRESETn;
  logic [NR+2:0] RSTCAUSE;
  logic          BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a sequence is active from its start edge until PRESETn
  // releases; age counts edges since the latest (re)start.
  bit          m_in_seq;
  int          m_age;
  bit          m_dbg_lo;
  logic [NR+2:0] m_cause;

  cmsdk_mcu_rstctrl #(
    .NUM_REQ   (NR),
    .RST_CYCLES(RC),
    .STAGGER   (ST)
  ) u_dut (
    .FCLK        (FCLK),
    .PORESET     (PORESET),
    .SYSRESETREQ (SYSRESETREQ),
    .REQ_MASK    (REQ_MASK),
    .LOCKUP      (LOCKUP),
    .LOCKUPRESET (LOCKUPRESET),
    .DBGRESETREQ (DBGRESETREQ),
    .RSTCAUSE_CLR(RSTCAUSE_CLR),
    .DBGRESETn   (DBGRESETn),
    .HRESETn     (HRESETn),
    .PRESETn     (PRESETn),
    .RSTCAUSE    (RSTCAUSE),
    .BUSY        (BUSY)
  );

  initial FCLK = 1'b0;
  always #5 FCLK = ~FCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_seq = 1'b1;
    m_age    = 0;
    m_dbg_lo = 1'b1;
    m_cause  = (NR+3)'(1);
  endtask

  task automatic model_edge();
    logic [NR-1:0] bits;
    logic          lk;
    logic          sreq;
    logic          dreq;
    bits = SYSRESETREQ & ~REQ_MASK;
    lk   = LOCKUP & LOCKUPRESET;
    sreq = (|bits) | lk;
    dreq = DBGRESETREQ;
    m_cause = (RSTCAUSE_CLR ? '0 : m_cause) | {bits, dreq, lk, 1'b0};
    if (!m_in_seq) begin
      if (sreq || dreq) begin
        m_in_seq = 1'b1;
        m_age    = 0;
        m_dbg_lo = dreq;
      end
    end else if (m_age < RC) begin
      if (dreq) m_dbg_lo = 1'b1;
      if (m_age == RC - 1) m_age = (sreq || dreq) ? 0 : RC;
      else m_age++;
    end else begin
      if (sreq || dreq) begin
        m_age    = 0;
        m_dbg_lo = dreq;
      end else begin
        m_age++;
        if (m_age == RC + 2*ST) m_in_seq = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("dbgresetn", 32'(DBGRESETn), 32'(!(m_in_seq && m_dbg_lo && m_age < RC)));
    check("hresetn",   32'(HRESETn),   32'(!(m_in_seq && m_age < RC + ST)));
    check("presetn",   32'(PRESETn),   32'(!m_in_seq));
    check("busy",      32'(BUSY),      32'(m_in_seq));
    check("rstcause",  32'(RSTCAUSE),  32'(m_cause));
  endtask

  // One clock: inputs sampled at posedge, outputs compared at following negedge
  task automatic step();
    @(posedge FCLK);
    model_edge();
    @(negedge FCLK);
    compare_all();
  endtask

  task automatic clear_inputs();
    SYSRESETREQ  = '0;
    REQ_MASK     = '0;
    LOCKUP       = 1'b0;
    LOCKUPRESET  = 1'b0;
    DBGRESETREQ  = 1'b0;
    RSTCAUSE_CLR = 1'b0;
  endtask

  logic [NR+2:0] saved_cause;
  int            hold_len;
  int            r;

  initial begin
    clear_inputs();
    PORESET = 1'b1;
    model_reset();
    repeat (3) @(negedge FCLK);
    check("por_dbg",   32'(DBGRESETn), 32'd0);
    check("por_h",     32'(HRESETn),   32'd0);
    check("por_p",     32'(PRESETn),   32'd0);
    check("por_busy",  32'(BUSY),      32'd1);
    check("por_cause", 32'(RSTCAUSE),  32'h01);
    PORESET = 1'b0;

    // Power-on release timeline
    for (int e = 1; e <= 21; e++) begin
      step();
      if (e == 15) check("por_dbg_e15", 32'(DBGRESETn), 32'd0);
      if (e == 16) check("por_dbg_e16", 32'(DBGRESETn), 32'd1);
      if (e == 17) check("por_h_e17",   32'(HRESETn),   32'd0);
      if (e == 18) check("por_h_e18",   32'(HRESETn),   32'd1);
      if (e == 19) check("por_p_e19",   32'(PRESETn),   32'd0);
      if (e == 20) check("por_p_e20",   32'(PRESETn),   32'd1);
      if (e == 20) check("por_busy_e20", 32'(BUSY),     32'd0);
    end
    check("por_cause_run", 32'(RSTCAUSE), 32'h01);

    // Single-cycle system request from RUN
    SYSRESETREQ = 4'b0010;
    step();
    SYSRESETREQ = '0;
    check("sys_h_low",  32'(HRESETn),   32'd0);
    check("sys_p_low",  32'(PRESETn),   32'd0);
    check("sys_dbg_hi", 32'(DBGRESETn), 32'd1);
    check("sys_cause",  32'(RSTCAUSE),  32'h11);
    for (int e = 1; e <= 18; e++) begin
      step();
      if (e == 17) check("sys_h_e17", 32'(HRESETn), 32'd0);
      if (e == 18) check("sys_h_e18", 32'(HRESETn), 32'd1);
    end

    // Debug request while in REL_P replays the full sequence
    DBGRESETREQ = 1'b1;
    step();
    DBGRESETREQ = 1'b0;
    check("dbg_all_low", 32'({DBGRESETn, HRESETn, PRESETn}), 32'd0);
    check("dbg_cause",   32'(RSTCAUSE), 32'h15);
    for (int e = 1; e <= 21; e++) begin
      step();
      if (e == 16) check("dbg_dbg_e16", 32'(DBGRESETn), 32'd1);
      if (e == 18) check("dbg_h_e18",   32'(HRESETn),   32'd1);
      if (e == 20) check("dbg_p_e20",   32'(PRESETn),   32'd1);
    end

    // Fully masked requests and lockup without LOCKUPRESET do nothing
    saved_cause = RSTCAUSE;
    SYSRESETREQ = 4'hF;
    REQ_MASK    = 4'hF;
    LOCKUP      = 1'b1;
    repeat (5) step();
    clear_inputs();
    check("mask_h",     32'(HRESETn),  32'd1);
    check("mask_busy",  32'(BUSY),     32'd0);
    check("mask_cause", 32'(RSTCAUSE), 32'(saved_cause));

    // Clear coincident with a lockup reset: the new cause wins
    RSTCAUSE_CLR = 1'b1;
    LOCKUP       = 1'b1;
    LOCKUPRESET  = 1'b1;
    step();
    clear_inputs();
    check("clr_lk_cause", 32'(RSTCAUSE), 32'h02);
    check("clr_lk_h",     32'(HRESETn),  32'd0);
    repeat (7) step();

    // Asynchronous power-on reset at counter 7
    #2 PORESET = 1'b1;
    #1;
    model_reset();
    check("async_outs",  32'({DBGRESETn, HRESETn, PRESETn}), 32'd0);
    check("async_busy",  32'(BUSY),     32'd1);
    check("async_cause", 32'(RSTCAUSE), 32'h01);
    @(negedge FCLK);
    PORESET = 1'b0;
    repeat (22) step();

    // Randomised episodes
    for (int ep = 0; ep < 30; ep++) begin
      REQ_MASK = NR'($urandom);
      hold_len = 0;
      if (ep % 6 == 3) begin
        REQ_MASK[2] = 1'b0;
        hold_len = $urandom_range(45, 20);
      end
      for (int c = 0; c < 70; c++) begin
        SYSRESETREQ  = '0;
        DBGRESETREQ  = 1'b0;
        LOCKUPRESET  = 1'b0;
        LOCKUP       = 1'($urandom_range(1, 0));
        RSTCAUSE_CLR = ($urandom_range(7, 0) == 0);
        r = $urandom_range(99, 0);
        if (c < hold_len) SYSRESETREQ[2] = 1'b1;
        else if (ep % 5 == 0) SYSRESETREQ = NR'($urandom);
        else if (r < 2) SYSRESETREQ = NR'($urandom);
        else if (r == 2) DBGRESETREQ = 1'b1;
        else if (r == 3) begin
          LOCKUP      = 1'b1;
          LOCKUPRESET = 1'b1;
        end else if (r == 4) LOCKUPRESET = 1'b1;
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
